// File: rtl/perf_counter_cmd_mux_if.sv
// Command/response and counter-slave bus bundle for perf_counter_cmd_mux.
// The "slave" modport is the mux itself: it accepts requester commands and
// drives the counter bus. The "master" modport is the environment, which
// plays both the requesters and the counter slave that returns av_readdata.
interface perf_counter_cmd_mux_if;
  // requester side, 4 ports packed as 1 bit (valid/ready) or 2 bits (op/sec) each
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [7:0]  req_sec;
  logic [3:0]  req_ready;
  // READ response
  logic        rsp_valid;
  logic [1:0]  rsp_port;
  logic [63:0] rsp_time;
  logic [31:0] rsp_events;
  logic        busy;
  // counter slave bus
  logic [3:0]  av_address;
  logic        av_write;
  logic        av_begintransfer;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;

  modport slave (
    input  req_valid, req_op, req_sec, av_readdata,
    output req_ready, rsp_valid, rsp_port, rsp_time, rsp_events, busy,
           av_address, av_write, av_begintransfer, av_writedata
  );

  modport master (
    output req_valid, req_op, req_sec, av_readdata,
    input  req_ready, rsp_valid, rsp_port, rsp_time, rsp_events, busy,
           av_address, av_write, av_begintransfer, av_writedata
  );
endinterface

// File: rtl/perf_counter_cmd_mux.sv
// Round-robin command mux: four requester ports share one counter slave.
// START/STOP/CLEAR_ALL become a single write; READ becomes a three-word read
// (time lo, time hi, events) returned as one response pulse. Every output
// comes straight from a flop.
module perf_counter_cmd_mux (
  input  logic                 clk,
  input  logic                 reset_n,
  perf_counter_cmd_mux_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD0, S_RD1, S_RD2, S_RD3, S_RSP
  } state_t;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLR   = 2'b10;

  state_t      state_q;
  logic [1:0]  last_q;       // last granted port, round-robin pointer
  logic [1:0]  port_q;       // port being serviced
  logic [1:0]  sec_q;        // section being serviced
  logic [31:0] time_lo_q;
  logic [31:0] time_hi_q;

  logic [3:0]  req_ready_q;
  logic        rsp_valid_q;
  logic [1:0]  rsp_port_q;
  logic [63:0] rsp_time_q;
  logic [31:0] rsp_events_q;
  logic        busy_q;
  logic [3:0]  av_address_q;
  logic        av_write_q;
  logic        av_begintransfer_q;
  logic [31:0] av_writedata_q;

  logic        gnt_found;
  logic [1:0]  gnt_idx;
  logic [1:0]  gnt_op;
  logic [1:0]  gnt_sec;

  // Round-robin pick: scan from last_q+1 upward (wrapping), first valid wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last_q;
    for (int k = 0; k < 4; k++) begin
      if (!gnt_found && bus.req_valid[last_q + 2'd1 + 2'(k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = last_q + 2'd1 + 2'(k);
      end
    end
    gnt_op  = bus.req_op[{gnt_idx, 1'b0} +: 2];
    gnt_sec = bus.req_sec[{gnt_idx, 1'b0} +: 2];
  end

  // Command FSM; outputs are set one state ahead so they appear registered
  // in the cycle of the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      last_q             <= 2'd3;
      port_q             <= '0;
      sec_q              <= '0;
      time_lo_q          <= '0;
      time_hi_q          <= '0;
      req_ready_q        <= '0;
      rsp_valid_q        <= 1'b0;
      rsp_port_q         <= '0;
      rsp_time_q         <= '0;
      rsp_events_q       <= '0;
      busy_q             <= 1'b0;
      av_address_q       <= '0;
      av_write_q         <= 1'b0;
      av_begintransfer_q <= 1'b0;
      av_writedata_q     <= '0;
    end else begin
      // single-cycle pulses default low
      req_ready_q        <= '0;
      rsp_valid_q        <= 1'b0;
      av_write_q         <= 1'b0;
      av_begintransfer_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            last_q      <= gnt_idx;
            port_q      <= gnt_idx;
            sec_q       <= gnt_sec;
            req_ready_q <= 4'b0001 << gnt_idx;
            busy_q      <= 1'b1;
            case (gnt_op)
              OP_START: begin
                av_address_q       <= {gnt_sec, 2'b01};
                av_writedata_q     <= 32'd0;
                av_write_q         <= 1'b1;
                av_begintransfer_q <= 1'b1;
                state_q            <= S_WR;
              end
              OP_STOP: begin
                av_address_q       <= {gnt_sec, 2'b00};
                av_writedata_q     <= 32'd0;
                av_write_q         <= 1'b1;
                av_begintransfer_q <= 1'b1;
                state_q            <= S_WR;
              end
              OP_CLR: begin
                // global clear lives in section 0's control word; sec ignored
                av_address_q       <= 4'd0;
                av_writedata_q     <= 32'd1;
                av_write_q         <= 1'b1;
                av_begintransfer_q <= 1'b1;
                state_q            <= S_WR;
              end
              default: begin
                av_address_q <= {gnt_sec, 2'b00};
                state_q      <= S_RD0;
              end
            endcase
          end
        end
        S_WR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_RD0: begin
          av_address_q <= {sec_q, 2'b01};
          state_q      <= S_RD1;
        end
        S_RD1: begin
          // slave data lags address by one cycle: this is word 4*sec
          time_lo_q    <= bus.av_readdata;
          av_address_q <= {sec_q, 2'b10};
          state_q      <= S_RD2;
        end
        S_RD2: begin
          time_hi_q <= bus.av_readdata;
          state_q   <= S_RD3;
        end
        S_RD3: begin
          rsp_valid_q  <= 1'b1;
          rsp_port_q   <= port_q;
          rsp_time_q   <= {time_hi_q, time_lo_q};
          rsp_events_q <= bus.av_readdata;
          state_q      <= S_RSP;
        end
        S_RSP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready        = req_ready_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_port         = rsp_port_q;
  assign bus.rsp_time         = rsp_time_q;
  assign bus.rsp_events       = rsp_events_q;
  assign bus.busy             = busy_q;
  assign bus.av_address       = av_address_q;
  assign bus.av_write         = av_write_q;
  assign bus.av_begintransfer = av_begintransfer_q;
  assign bus.av_writedata     = av_writedata_q;

endmodule

// File: tb/tb_perf_counter_cmd_mux.sv
// Directed bench for perf_counter_cmd_mux with a registered counter-slave model.
module tb_perf_counter_cmd_mux;
  logic clk;
  logic reset_n;
  perf_counter_cmd_mux_if bus ();

  perf_counter_cmd_mux dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // counter slave: read data registered, valid the cycle after the address
  logic [31:0] mem [16];
  always @(posedge clk) bus.av_readdata <= mem[bus.av_address];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_ready"},   64'(bus.req_ready), 64'd0);
    chk({pfx, "_rspv"},    64'(bus.rsp_valid), 64'd0);
    chk({pfx, "_rspport"}, 64'(bus.rsp_port), 64'd0);
    chk({pfx, "_time"},    bus.rsp_time, 64'd0);
    chk({pfx, "_events"},  64'(bus.rsp_events), 64'd0);
    chk({pfx, "_busy"},    64'(bus.busy), 64'd0);
    chk({pfx, "_addr"},    64'(bus.av_address), 64'd0);
    chk({pfx, "_wr"},      64'(bus.av_write), 64'd0);
    chk({pfx, "_bt"},      64'(bus.av_begintransfer), 64'd0);
    chk({pfx, "_wdata"},   64'(bus.av_writedata), 64'd0);
  endtask

  // Port p READ of section 2: request sampled at edge T, response at T+5.
  task automatic run_read(input int p);
    bus.req_op[2*p +: 2]  = 2'b11;
    bus.req_sec[2*p +: 2] = 2'd2;
    bus.req_valid[p]      = 1'b1;
    @(posedge clk); @(negedge clk);            // T+1 (RD0)
    chk("rd_ready", 64'(bus.req_ready), 64'(4'b0001 << p));
    chk("rd_addr0", 64'(bus.av_address), 64'd8);
    chk("rd_wr",    64'(bus.av_write), 64'd0);
    chk("rd_busy",  64'(bus.busy), 64'd1);
    bus.req_valid[p] = 1'b0;
    @(posedge clk); @(negedge clk);            // T+2
    chk("rd_addr1", 64'(bus.av_address), 64'd9);
    chk("rd_ready_clr", 64'(bus.req_ready), 64'd0);
    @(posedge clk); @(negedge clk);            // T+3
    chk("rd_addr2", 64'(bus.av_address), 64'd10);
    @(posedge clk); @(negedge clk);            // T+4
    chk("rd_rspv_early", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk); @(negedge clk);            // T+5
    chk("rd_rspv",   64'(bus.rsp_valid), 64'd1);
    chk("rd_port",   64'(bus.rsp_port), 64'(p));
    chk("rd_time",   bus.rsp_time, 64'h0000_0022_0000_0011);
    chk("rd_events", 64'(bus.rsp_events), 64'h33);
    @(posedge clk); @(negedge clk);            // T+6 back in IDLE
    chk("rd_rspv_clr", 64'(bus.rsp_valid), 64'd0);
    chk("rd_time_hold", bus.rsp_time, 64'h0000_0022_0000_0011);
    chk("rd_busy_clr", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clk = 1'b0;
    reset_n = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_sec   = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hA0 + 32'(i);
    mem[8]  = 32'h11;
    mem[9]  = 32'h22;
    mem[10] = 32'h33;

    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);

    // all four ports STOP sec 3 at once: grants 0,1,2,3 two cycles apart
    bus.req_op    = 8'h55;
    bus.req_sec   = 8'hFF;
    bus.req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      chk("stop_ready", 64'(bus.req_ready), 64'(4'b0001 << k));
      chk("stop_addr",  64'(bus.av_address), 64'd12);
      chk("stop_wr",    64'(bus.av_write), 64'd1);
      chk("stop_wdata", 64'(bus.av_writedata), 64'd0);
      bus.req_valid[k] = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("stop_wr_clr", 64'(bus.av_write), 64'd0);
      chk("stop_busy_clr", 64'(bus.busy), 64'd0);
    end

    // port 2 START sec 1
    bus.req_op  = 8'h00;
    bus.req_sec = 8'b00_01_00_00;
    bus.req_valid = 4'b0100;
    @(posedge clk); @(negedge clk);
    chk("start_addr",  64'(bus.av_address), 64'd5);
    chk("start_wr",    64'(bus.av_write), 64'd1);
    chk("start_bt",    64'(bus.av_begintransfer), 64'd1);
    chk("start_wdata", 64'(bus.av_writedata), 64'd0);
    chk("start_ready", 64'(bus.req_ready), 64'b0100);
    chk("start_busy",  64'(bus.busy), 64'd1);
    bus.req_valid = '0;
    @(posedge clk); @(negedge clk);
    chk("start_wr_clr",    64'(bus.av_write), 64'd0);
    chk("start_bt_clr",    64'(bus.av_begintransfer), 64'd0);
    chk("start_ready_clr", 64'(bus.req_ready), 64'd0);
    chk("start_addr_hold", 64'(bus.av_address), 64'd5);

    // port 1 READ sec 2
    bus.req_op = '0; bus.req_sec = '0;
    run_read(1);

    // port 3 CLEAR_ALL sec 2: sec ignored, address 0 data 1
    bus.req_op  = 8'b10_00_00_00;
    bus.req_sec = 8'b10_00_00_00;
    bus.req_valid = 4'b1000;
    @(posedge clk); @(negedge clk);
    chk("clr_ready", 64'(bus.req_ready), 64'b1000);
    chk("clr_addr",  64'(bus.av_address), 64'd0);
    chk("clr_wdata", 64'(bus.av_writedata), 64'd1);
    chk("clr_wr",    64'(bus.av_write), 64'd1);
    bus.req_valid = '0;
    @(posedge clk); @(negedge clk);
    chk("clr_wr_clr", 64'(bus.av_write), 64'd0);

    // fairness: port 0 (STOP sec 1) and port 2 (START sec 3); last granted 3
    bus.req_op  = 8'b00_00_00_01;
    bus.req_sec = 8'b00_11_00_01;
    bus.req_valid = 4'b0101;
    @(posedge clk); @(negedge clk);
    chk("rr_first",      64'(bus.req_ready), 64'b0001);
    chk("rr_first_addr", 64'(bus.av_address), 64'd4);
    // port 0 keeps requesting (new command) while port 2 still waits
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("rr_second",      64'(bus.req_ready), 64'b0100);
    chk("rr_second_addr", 64'(bus.av_address), 64'd13);
    bus.req_valid[2] = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("rr_third", 64'(bus.req_ready), 64'b0001);
    bus.req_valid = '0;
    @(posedge clk); @(negedge clk);

    // reset during RD2 of a READ: outputs clear at once, no response
    bus.req_op  = 8'b00_00_11_00;
    bus.req_sec = 8'b00_00_10_00;
    bus.req_valid = 4'b0010;
    @(posedge clk); @(negedge clk);            // RD0
    chk("mid_ready", 64'(bus.req_ready), 64'b0010);
    bus.req_valid = '0;
    @(posedge clk); @(negedge clk);            // RD1
    @(posedge clk); @(negedge clk);            // RD2
    chk("mid_addr", 64'(bus.av_address), 64'd10);
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      chk("post_rst_rspv", 64'(bus.rsp_valid), 64'd0);
      chk("post_rst_busy", 64'(bus.busy), 64'd0);
    end
    bus.req_op = '0; bus.req_sec = '0;
    run_read(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/perf_counter_cmd_mux.md
PERF_COUNTER_CMD_MUX -- requirements
Module: perf_counter_cmd_mux

Interface
REQ-001 The block SHALL have no parameters; it serves exactly 4 requester ports (index 0..3) and 4 counter sections (0..3).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  4  per-port command request; held until accepted.
REQ-005 req_op  input  8  per-port 2-bit opcode at [2p+1:2p]: 00 START, 01 STOP, 10 CLEAR_ALL, 11 READ.
REQ-006 req_sec  input  8  per-port 2-bit section number at [2p+1:2p].
REQ-007 req_ready  output  4  one-cycle acceptance pulse for port p.
REQ-008 rsp_valid  output  1  one-cycle pulse; READ result valid.
REQ-009 rsp_port  output  2  port that issued the READ.
REQ-010 rsp_time  output  64  captured section time count.
REQ-011 rsp_events  output  32  captured section event count.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 av_address  output  4  counter slave word address.
REQ-014 av_write  output  1  counter slave write.
REQ-015 av_begintransfer  output  1  counter slave begintransfer.
REQ-016 av_writedata  output  32  counter slave write data.
REQ-017 av_readdata  input  32  counter slave read data; registered in the slave, valid the cycle after av_address is driven.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 States SHALL be IDLE, WR, RD0, RD1, RD2, RD3, RSP.
REQ-020 IDLE: if any req_valid, grant one port round-robin, starting at (last granted + 1) mod 4; last granted resets to 3, so port 0 wins first.
REQ-021 On grant, latch op and sec; next state WR for START/STOP/CLEAR_ALL, RD0 for READ.
REQ-022 req_ready[p] SHALL be high exactly in the cycle after grant (first WR or RD0 cycle), one bit at most, for one cycle.
REQ-023 WR, single cycle: av_write=1, av_begintransfer=1. START: address 4*sec+1, data 0. STOP: address 4*sec, data 0. CLEAR_ALL: address 0, data 1. Next state IDLE.
REQ-024 CLEAR_ALL SHALL ignore req_sec; the side effect on section 0 (counters cleared, section 0 stopped) is intended.
REQ-025 RD0: drive address 4*sec. RD1: drive 4*sec+1, capture readdata to time[31:0]. RD2: drive 4*sec+2, capture time[63:32]. RD3: capture events. Next state RSP. av_write=0 and av_begintransfer=0 throughout.
REQ-026 RSP: rsp_valid=1 for one cycle with rsp_port, rsp_time, rsp_events; next state IDLE. No backpressure exists on the response.
REQ-027 rsp_time/rsp_events/rsp_port SHALL hold their last value when rsp_valid=0.
REQ-028 av_address SHALL hold its last value when idle.
REQ-029 No tear correction: a READ of a running section may return an inconsistent lo/hi pair; software stops the section before READ.
REQ-030 Requests arriving in a non-IDLE state SHALL wait; a request is accepted at the earliest one cycle after return to IDLE.
REQ-031 Latency from req_valid (sampled in IDLE at cycle T): write on slave bus at T+1, READ rsp_valid at T+5; a write accept-to-accept occupies 2 cycles, a READ occupies 6.
REQ-032 A port dropping req_valid before req_ready is a protocol violation; the block behaviour is unspecified.

Reset
REQ-033 reset_n low SHALL immediately force IDLE; all outputs 0; captured data 0; last granted 3; an in-flight command is discarded with no response.

Verification
REQ-034 Port 2 START sec 1 -> T+1: av_address=5, av_write=1, av_begintransfer=1, av_writedata=0, req_ready=0100.
REQ-035 All 4 ports request STOP sec 3 at once from reset -> grants in order 0,1,2,3, each writing address 12, 2 cycles apart.
REQ-036 Port 1 READ sec 2, slave model returns 0x11 at addr 8, 0x22 at addr 9, 0x33 at addr 10 -> T+5: rsp_valid=1, rsp_port=1, rsp_time=0x0000002200000011, rsp_events=0x33.
REQ-037 Port 3 CLEAR_ALL sec 2 -> address 0, writedata 1, av_write=1 for one cycle.
REQ-038 reset_n asserted during RD2 -> outputs 0 at once, no rsp_valid; after release, a new request is serviced normally.
REQ-039 Port 0 re-requests immediately after ready with port 2 pending -> port 2 granted next (round-robin fairness).
